// File: rtl/fault_sweep_pkg.sv
// fault_sweep_pkg
// Shared definitions for the fault sweep engine: default geometry, the
// sweep state enum, the fault index constants of the bench CUT and the
// helper that turns a fault index into a one-hot injection enable.
// Ports: none (package).
package fault_sweep_pkg;

  localparam int FSIM_NUM_IN     = 3;
  localparam int FSIM_NUM_FAULTS = 5;
  localparam int FSIM_SETTLE     = 1;
  localparam int FSIM_OH_MAX     = 32;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    SAMPLE,
    NEXT,
    DONE
  } state_t;

  localparam int FLT_NONE  = 0;
  localparam int FLT_A_SA1 = 1;
  localparam int FLT_B_SA0 = 2;
  localparam int FLT_C_SA1 = 3;
  localparam int FLT_E_SA1 = 4;
  localparam int FLT_F_SA0 = 5;

  // Fault k enables bit k-1; index 0 (fault-free) gives all zeros.
  // Callers truncate the result to their own fault count.
  function automatic logic [FSIM_OH_MAX-1:0] fault_onehot(input int unsigned idx);
    logic [FSIM_OH_MAX-1:0] oh;
    oh = '0;
    if (idx != 0) begin
      oh = FSIM_OH_MAX'(1) << (idx - 1);
    end
    return oh;
  endfunction

endpackage

// File: rtl/fault_sweep_compare.sv
// fault_sweep_compare
// Result storage for the sweep: golden response vector, per-fault
// detection mask and the registered det_* report of each faulty sample.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           wipe golden and detect_mask (sweep start)
//   sample_en       store/compare the sampled response this cycle
//   fault, pattern  index of the sample being stored
//   resp_bit        registered CUT response
//   golden          fault-free response, bit i = pattern i
//   detect_mask     slice k-1 = fault k, bit i = pattern i detects it
//   det_valid/det_fault/det_pat/det_hit  one-cycle report per faulty sample
module fault_sweep_compare
  import fault_sweep_pkg::*;
#(
  parameter int NUM_IN     = FSIM_NUM_IN,
  parameter int NUM_FAULTS = FSIM_NUM_FAULTS,
  localparam int NP        = 1 << NUM_IN,
  localparam int FW        = $clog2(NUM_FAULTS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     sample_en,
  input  logic [FW-1:0]            fault,
  input  logic [NUM_IN-1:0]        pattern,
  input  logic                     resp_bit,
  output logic [NP-1:0]            golden,
  output logic [NUM_FAULTS*NP-1:0] detect_mask,
  output logic                     det_valid,
  output logic [FW-1:0]            det_fault,
  output logic [NUM_IN-1:0]        det_pat,
  output logic                     det_hit
);

  logic [NP-1:0]                  golden_q;
  logic [NUM_FAULTS-1:0][NP-1:0]  mask_q;
  logic [FW-1:0]                  slot;
  logic                           hit;

  // Fault k lives in mask slot k-1; a hit is any deviation from golden.
  assign slot        = fault - FW'(1);
  assign hit         = resp_bit ^ golden_q[pattern];
  assign golden      = golden_q;
  assign detect_mask = mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      golden_q  <= '0;
      mask_q    <= '0;
      det_valid <= 1'b0;
      det_fault <= '0;
      det_pat   <= '0;
      det_hit   <= 1'b0;
    end else begin
      det_valid <= 1'b0;
      if (clear) begin
        golden_q <= '0;
        mask_q   <= '0;
      end else if (sample_en) begin
        if (fault == '0) begin
          golden_q[pattern] <= resp_bit;
        end else begin
          mask_q[slot][pattern] <= hit;
          det_valid             <= 1'b1;
          det_fault             <= fault;
          det_pat               <= pattern;
          det_hit               <= hit;
        end
      end
    end
  end

endmodule

// File: rtl/fault_sweep_engine.sv
// fault_sweep_engine
// Apply-and-compare engine for parallel single-stuck-at fault simulation.
// Sweeps a fault-free pass followed by one pass per fault, applying every
// exhaustive pattern, and collects golden and detection results.
// Optional feature: define FSIM_FAULT_DROP_EN to skip the remaining
// patterns of a fault after its first detection.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin a sweep (honoured in IDLE or DONE only)
//   pat             pattern index driven to the CUT, MSB = input a
//   fault_sel       one-hot fault enable to the CUT wrapper
//   resp            CUT output
//   busy, done      sweep in progress / sweep finished
//   golden, detect_mask, det_*   results from fault_sweep_compare
module fault_sweep_engine
  import fault_sweep_pkg::*;
#(
  parameter int NUM_IN     = FSIM_NUM_IN,
  parameter int NUM_FAULTS = FSIM_NUM_FAULTS,
  parameter int SETTLE     = FSIM_SETTLE,
  localparam int NP        = 1 << NUM_IN,
  localparam int FW        = $clog2(NUM_FAULTS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [NUM_IN-1:0]        pat,
  output logic [NUM_FAULTS-1:0]    fault_sel,
  input  logic                     resp,
  output logic                     busy,
  output logic                     done,
  output logic [NP-1:0]            golden,
  output logic [NUM_FAULTS*NP-1:0] detect_mask,
  output logic                     det_valid,
  output logic [FW-1:0]            det_fault,
  output logic [NUM_IN-1:0]        det_pat,
  output logic                     det_hit
);

  localparam int HC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

`ifdef FSIM_FAULT_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  localparam logic [NUM_IN-1:0] LAST_PAT   = NUM_IN'(NP - 1);
  localparam logic [FW-1:0]     LAST_FAULT = FW'(NUM_FAULTS);
  localparam logic [HC_W-1:0]   HOLD_LAST  = HC_W'(SETTLE - 1);

  state_t            state;
  logic [FW-1:0]     fault;
  logic [NUM_IN-1:0] pattern;
  logic [HC_W-1:0]   hold_cnt;
  logic              resp_q;
  logic              clear;
  logic              sample_en;
  logic              drop_now;

  assign pat       = pattern;
  assign clear     = start && (state == IDLE || state == DONE);
  assign sample_en = (state == SAMPLE);
  // det_hit is fresh during NEXT, so a detected fault can be abandoned here.
  assign drop_now  = DROP_EN && (fault != '0) && det_valid && det_hit;

  // Sweep sequencer. The response is captured on the edge that ends the
  // last HOLD cycle; fault_sel is dropped to fault-free on leaving SAMPLE so
  // injection only ever overlaps the HOLD/SAMPLE cycles of one fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fault     <= '0;
      pattern   <= '0;
      hold_cnt  <= '0;
      resp_q    <= 1'b0;
      fault_sel <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            fault     <= '0;
            pattern   <= '0;
            hold_cnt  <= '0;
            fault_sel <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            resp_q <= resp;
            state  <= SAMPLE;
          end else begin
            hold_cnt <= hold_cnt + HC_W'(1);
          end
        end
        SAMPLE: begin
          fault_sel <= '0;
          state     <= NEXT;
        end
        NEXT: begin
          hold_cnt <= '0;
          if (!drop_now && pattern != LAST_PAT) begin
            pattern   <= pattern + NUM_IN'(1);
            fault_sel <= NUM_FAULTS'(fault_onehot(32'(fault)));
            state     <= HOLD;
          end else if (fault != LAST_FAULT) begin
            pattern   <= '0;
            fault     <= fault + FW'(1);
            fault_sel <= NUM_FAULTS'(fault_onehot(32'(fault) + 32'd1));
            state     <= HOLD;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fault_sweep_compare #(
    .NUM_IN     (NUM_IN),
    .NUM_FAULTS (NUM_FAULTS)
  ) u_compare (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .sample_en   (sample_en),
    .fault       (fault),
    .pattern     (pattern),
    .resp_bit    (resp_q),
    .golden      (golden),
    .detect_mask (detect_mask),
    .det_valid   (det_valid),
    .det_fault   (det_fault),
    .det_pat     (det_pat),
    .det_hit     (det_hit)
  );

endmodule

// File: tb/tb_fault_sweep_engine.sv
// tb_fault_sweep_engine
// Self-checking bench for fault_sweep_engine. Hosts the CUT e=a&b, f=e|c
// with stuck-at injection on a, b, c, e, f. Expected det_* reports are
// queued from a sweep-level reference model and popped by a monitor.
// Honours FSIM_FAULT_DROP_EN the same way as the design.
module tb_fault_sweep_engine;

  localparam int NUM_IN = 3;
  localparam int NF     = 5;
  localparam int NP     = 8;
  localparam int FW     = 3;
  localparam int PCYC   = 3;

`ifdef FSIM_FAULT_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [NUM_IN-1:0] pat;
  logic [NF-1:0]     fault_sel;
  logic              resp;
  logic              busy;
  logic              done;
  logic [NP-1:0]     golden;
  logic [NF*NP-1:0]  detect_mask;
  logic              det_valid;
  logic [FW-1:0]     det_fault;
  logic [NUM_IN-1:0] det_pat;
  logic              det_hit;

  always #5 clk = ~clk;

  fault_sweep_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pat         (pat),
    .fault_sel   (fault_sel),
    .resp        (resp),
    .busy        (busy),
    .done        (done),
    .golden      (golden),
    .detect_mask (detect_mask),
    .det_valid   (det_valid),
    .det_fault   (det_fault),
    .det_pat     (det_pat),
    .det_hit     (det_hit)
  );

  // CUT wrapper with injection muxes.
  logic cut_a, cut_b, cut_c, cut_e, cut_f;
  always_comb begin
    cut_a = fault_sel[0] ? 1'b1 : pat[2];
    cut_b = fault_sel[1] ? 1'b0 : pat[1];
    cut_c = fault_sel[2] ? 1'b1 : pat[0];
    cut_e = fault_sel[3] ? 1'b1 : (cut_a & cut_b);
    cut_f = fault_sel[4] ? 1'b0 : (cut_e | cut_c);
    resp  = cut_f;
  end

  typedef struct {
    int fault;
    int pat;
    bit hit;
  } det_t;

  det_t                 exp_q[$];
  int                   n_checks = 0;
  int                   n_fails  = 0;
  int                   det_cnt  = 0;
  int                   hit_cnt  = 0;
  logic [NP-1:0]        exp_golden;
  logic [NF-1:0][NP-1:0] exp_mask;
  int                   exp_cycles;
  int                   exp_dets;
  int                   exp_hits;

  // Literal results for the bench CUT.
  logic [7:0] lit_mask_full [NF] = '{8'h04, 8'h40, 8'h15, 8'h15, 8'hEA};
  logic [7:0] lit_mask_drop [NF] = '{8'h04, 8'h40, 8'h01, 8'h01, 8'h02};

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Behavioural CUT under fault k, pattern p = {a,b,c}.
  function automatic bit cutModel(input int k, input int p);
    bit a, b, c, e, f;
    a = p[2];
    b = p[1];
    c = p[0];
    if (k == 1) a = 1'b1;
    if (k == 2) b = 1'b0;
    if (k == 3) c = 1'b1;
    e = a & b;
    if (k == 4) e = 1'b1;
    f = e | c;
    if (k == 5) f = 1'b0;
    return f;
  endfunction

  // Sweep-level model: fault-free pass, then each fault in order,
  // optionally abandoning a fault at its first detection.
  task automatic buildModel();
    bit h;
    exp_q.delete();
    exp_golden = '0;
    exp_mask   = '0;
    exp_dets   = 0;
    exp_hits   = 0;
    for (int p = 0; p < NP; p++) exp_golden[p] = cutModel(0, p);
    exp_cycles = NP * PCYC;
    for (int k = 1; k <= NF; k++) begin
      for (int p = 0; p < NP; p++) begin
        h = cutModel(k, p) ^ exp_golden[p];
        exp_q.push_back('{fault: k, pat: p, hit: h});
        exp_dets++;
        exp_cycles += PCYC;
        if (h) begin
          exp_mask[k-1][p] = 1'b1;
          exp_hits++;
          if (DROP) break;
        end
      end
    end
  endtask

  // Monitor: every det_valid pulse must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && det_valid) begin
      det_cnt++;
      if (det_hit) hit_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL det_unexpected: actual fault=%0d pat=%0d required no pulse", det_fault, det_pat);
      end else begin
        det_t e;
        e = exp_q.pop_front();
        checkOutput("det_fault", 64'(det_fault), 64'(e.fault));
        checkOutput("det_pat", 64'(det_pat), 64'(e.pat));
        checkOutput("det_hit", 64'(det_hit), 64'(e.hit));
      end
    end
  end

  task automatic checkReset(input string tag);
    checkOutput({tag, "_pat"}, 64'(pat), 64'(0));
    checkOutput({tag, "_fault_sel"}, 64'(fault_sel), 64'(0));
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_done"}, 64'(done), 64'(0));
    checkOutput({tag, "_golden"}, 64'(golden), 64'(0));
    checkOutput({tag, "_mask"}, 64'(detect_mask), 64'(0));
    checkOutput({tag, "_det_valid"}, 64'(det_valid), 64'(0));
    checkOutput({tag, "_det_fault"}, 64'(det_fault), 64'(0));
    checkOutput({tag, "_det_pat"}, 64'(det_pat), 64'(0));
    checkOutput({tag, "_det_hit"}, 64'(det_hit), 64'(0));
  endtask

  // Start a sweep and count cycles until done; optionally pulse start
  // once mid-sweep, which must be ignored.
  task automatic applyStimulus(input bit poke_start, output int cycles);
    int poke;
    buildModel();
    det_cnt = 0;
    hit_cnt = 0;
    cycles  = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("start_clear_golden", 64'(golden), 64'(0));
    checkOutput("start_clear_mask", 64'(detect_mask), 64'(0));
    checkOutput("start_busy", 64'(busy), 64'(1));
    checkOutput("start_done", 64'(done), 64'(0));
    poke = poke_start ? int'($urandom_range(5, exp_cycles - 10)) : -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      start = (i == poke);
      if (done) begin
        cycles = i;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic checkResults(input string tag, input int cycles);
    checkOutput({tag, "_cycles"}, 64'(cycles), 64'(exp_cycles));
    checkOutput({tag, "_done"}, 64'(done), 64'(1));
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_golden"}, 64'(golden), 64'(exp_golden));
    checkOutput({tag, "_golden_lit"}, 64'(golden), 64'(8'hEA));
    for (int k = 0; k < NF; k++) begin
      checkOutput($sformatf("%s_mask%0d", tag, k + 1), 64'(detect_mask[k*NP +: NP]), 64'(exp_mask[k]));
      checkOutput($sformatf("%s_mask%0d_lit", tag, k + 1), 64'(detect_mask[k*NP +: NP]),
                  64'(DROP ? lit_mask_drop[k] : lit_mask_full[k]));
    end
    checkOutput({tag, "_det_count"}, 64'(det_cnt), 64'(exp_dets));
    checkOutput({tag, "_hit_count"}, 64'(hit_cnt), 64'(exp_hits));
    checkOutput({tag, "_queue_left"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int  cyc;
    bit  seen;
    rst_n = 1'b0;
    start = 1'b0;
    #12;
    checkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat ($urandom_range(1, 5)) @(negedge clk);

    $display("[TB] plain sweep");
    applyStimulus(1'b0, cyc);
    checkResults("run1", cyc);

    $display("[TB] restart from DONE with start poked while busy");
    repeat ($urandom_range(0, 4)) @(negedge clk);
    applyStimulus(1'b1, cyc);
    checkResults("run2", cyc);

    $display("[TB] reset during fault 3 pass");
    buildModel();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (fault_sel == 5'b00100) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("reach_fault3", 64'(seen), 64'(1));
    repeat ($urandom_range(0, 1)) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkReset("abort");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);

    $display("[TB] sweep after abort");
    applyStimulus(1'b1, cyc);
    checkResults("run3", cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
